// File: rtl/falling_target_lane.sv
// falling_target_lane
//   One lane of the falling-bit playfield. An 8-bit LFSR supplies a target
//   that drops one row per fall interval. The lane pulses `correct` when the
//   player's switches match the target. It raises `game_over` when the target
//   reaches the bottom row without being matched.
//
//   Optional feature: define FALLING_TARGET_SPEEDUP_EN to shorten the fall
//   interval as the hit count grows. Without it, the interval is FALL_CYCLES
//   and there is no hit counter.
//
// Ports
//   clock         in   system clock, rising edge
//   reset_button  in   asynchronous active-high reset
//   reset_signal  in   synchronous round clear (level)
//   switches[7:0] in   player switch word (already synchronized)
//   target[7:0]   out  current target value
//   row[2:0]      out  current row of the target (0 = top)
//   active        out  high while the target is falling
//   correct       out  one-cycle pulse per hit
//   game_over     out  level, target reached the bottom unmatched

module falling_target_lane #(
  parameter int unsigned LANE_HEIGHT = 6,
  parameter int unsigned FALL_CYCLES = 25000000,
  parameter logic [7:0]  SEED        = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_button,
  input  logic       reset_signal,
  input  logic [7:0] switches,
  output logic [7:0] target,
  output logic [2:0] row,
  output logic       active,
  output logic       correct,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_FALL,
    S_HIT,
    S_LOST
  } state_t;

  // An all-zero seed would lock the LFSR up.
  localparam logic [7:0]  SEED_NZ  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [25:0] FC26     = 26'(FALL_CYCLES);
  localparam logic [2:0]  ROW_LAST = 3'(LANE_HEIGHT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_lfsr;
  logic [25:0] r_cnt;
  logic [7:0]  r_target;
  logic [2:0]  r_row;
  logic        r_active;
  logic        r_correct;
  logic        r_game_over;
  logic        w_match;
  logic        w_last;
  logic        w_bottom;

`ifdef FALLING_TARGET_SPEEDUP_EN
  logic [3:0]  r_hits;
  logic [25:0] r_interval;
  logic [25:0] w_spawn_interval;

  always_comb begin
    w_spawn_interval = FC26;
    if (r_hits >= 4'd8)      w_spawn_interval = FC26 >> 2;
    else if (r_hits >= 4'd4) w_spawn_interval = FC26 >> 1;
  end

  // The hit count saturates at 15. The interval is latched at SPAWN, so a new
  // speed takes effect only on the next target.
  always_ff @(posedge clock or posedge reset_button) begin
    if (reset_button) begin
      r_hits     <= '0;
      r_interval <= FC26;
    end else begin
      if (reset_signal)
        r_hits <= '0;
      else if (r_state == S_HIT && r_hits != 4'hF)
        r_hits <= r_hits + 4'd1;
      if (!reset_signal && r_state == S_SPAWN)
        r_interval <= w_spawn_interval;
    end
  end

  assign w_last = (r_cnt == r_interval - 26'd1);
`else
  assign w_last = (r_cnt == FC26 - 26'd1);
`endif

  assign w_match  = (switches == r_target);
  assign w_bottom = (r_row == ROW_LAST);

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1. It free-runs in every state.
  always_ff @(posedge clock or posedge reset_button) begin
    if (reset_button)
      r_lfsr <= SEED_NZ;
    else
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  always_ff @(posedge clock or posedge reset_button) begin
    if (reset_button) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  // If a match and bottom expiry arrive together, the match wins.
  always_comb begin
    w_next = r_state;
    if (reset_signal) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  w_next = S_SPAWN;
        S_SPAWN: w_next = S_FALL;
        S_FALL: begin
          if (w_match)              w_next = S_HIT;
          else if (w_last && w_bottom) w_next = S_LOST;
        end
        S_HIT:   w_next = S_SPAWN;
        S_LOST:  w_next = S_LOST;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // The status flags are registered from the next state, so they line up with
  // the state they describe.
  always_ff @(posedge clock or posedge reset_button) begin
    if (reset_button) begin
      r_active    <= 1'b0;
      r_correct   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_active    <= (w_next == S_FALL);
      r_correct   <= (w_next == S_HIT);
      r_game_over <= (w_next == S_LOST);
    end
  end

  always_ff @(posedge clock or posedge reset_button) begin
    if (reset_button) begin
      r_target <= '0;
      r_row    <= '0;
      r_cnt    <= '0;
    end else if (reset_signal) begin
      r_target <= '0;
      r_row    <= '0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        S_SPAWN: begin
          // Invert a spawn that already matches the switches so that it
          // cannot score immediately.
          r_target <= (r_lfsr == switches) ? ~r_lfsr : r_lfsr;
          r_row    <= '0;
          r_cnt    <= '0;
        end
        S_FALL: begin
          if (!w_match) begin
            if (w_last) begin
              r_cnt <= '0;
              if (!w_bottom) r_row <= r_row + 3'd1;
            end else begin
              r_cnt <= r_cnt + 26'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign target    = r_target;
  assign row       = r_row;
  assign active    = r_active;
  assign correct   = r_correct;
  assign game_over = r_game_over;

endmodule
